coax_tx_sequencer: RTL and testbench
====================================

# coax_tx_sequencer

Frame-level transmit controller for the 3270 coax interface. It accepts 10-bit words over a valid/ready handshake and sequences the bit-period timing to drive the serial line. Each frame is a start sequence, one or more words (sync bit, data, optional parity), then an end sequence. It sits between the host-side transmit FIFO and the line driver.

## Interface
- `CLOCKS_PER_BIT`, default 8: clocks per bit period. Must be even and ≥4; the half-bit length is `CLOCKS_PER_BIT/2`.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `data` input 10: word to transmit, MSB first.
- `valid` input 1: `data` is presented.
- `ready` output 1: the holding register is empty; a word is accepted on `valid && ready`.
- `tx` output 1: serial line level.
- `active` output 1: high while a frame is being transmitted.

## Operation
- One-word holding register with a full flag; `ready = ~full`.
- Bit encoding: bit b drives `~b` for the first half-period and `b` for the second, so '1' is low→high and '0' is high→low.
- States:
  - IDLE: `tx=0`, `active=0`. Enter START when `full` is set.
  - START: 5 line-quiesce bits, each '1'.
  - CV: code violation; `tx=0` for 3 half-periods, then `tx=1` for 3 half-periods.
  - SYNC: one '1' bit. On entry, the holding register moves into the shift register, `full` clears and `ready` rises.
  - DATA: 10 bits, `data[9]` first.
  - PARITY: one bit chosen so that the total count of ones over data plus parity is even.
  - After the last word bit: go to SYNC if `full`, else go to END.
  - END: one '0' bit, then `tx=1` for one full bit period, then IDLE.
- The internal phase counter (0..`CLOCKS_PER_BIT`-1) restarts at 0 on the IDLE→START transition. Every state transition happens on the last clock of a bit or half-bit period.
- Arithmetic: the phase counter is `$clog2(CLOCKS_PER_BIT)+1` bits wide and wraps to 0 after `CLOCKS_PER_BIT-1`. The bit index counter is 4 bits; the half-bit counter is 3 bits.

## Timing
- Reset values: `tx=0`, `active=0`, `ready=1`, `full=0`, state IDLE, phase 0. Reset mid-frame aborts immediately and discards the holding register.
- Latency: a word accepted in cycle N sets `full` at N+1. The first clock of the first quiesce bit, with `active=1`, is N+2.
- `active` rises on the first START clock. It falls on the first IDLE clock after END.
- `ready` stays low from the acceptance clock+1 until the first SYNC clock of that word.
- Back-to-back words are accepted if `valid` arrives before the last clock of the current word's final bit. A word arriving later starts a new frame after END.
- Simultaneous `valid` with the SYNC load cycle: the word is not accepted, because `ready` is still low that cycle. It is accepted in the next cycle.
- With `CLOCKS_PER_BIT=8`, a single-word frame with parity lasts 22 bit periods = 176 clocks of `active`.

## Configuration
- `COAX_TX_PARITY_EN`:
  - Defined: the PARITY state is present and each word is 12 bits (sync, 10 data, parity).
  - Undefined: the PARITY state is removed. DATA proceeds directly to SYNC or END, each word is 11 bits, and a single-word frame lasts 21 bit periods = 168 clocks.

## Test plan
- Single word, `CLOCKS_PER_BIT=8`, parity on, `data=0x001` accepted at cycle N:
  - `active` high from N+2 for 176 clocks.
  - Line shows 5×'1', CV (low 12 clocks, high 12 clocks), sync '1', data 0000000001, parity '1', '0', high 8 clocks.
  - Then `tx=0`.
- Parity check: `data=0x3FF` gives parity bit '0`; `data=0x2A5` gives parity bit '1'.
- Back-to-back: second word presented while the first is in DATA.
  - Its sync bit immediately follows the first word's parity bit, with no END/START between.
  - `ready` rises on that SYNC entry.
- Late word: second word presented after END begins.
  - It gets a full new frame with a START sequence.
  - `active` drops for at least 1 clock between frames.
- Handshake hold: `valid` held high while `ready=0`. Exactly one word is accepted per SYNC load, and `data` is sampled only on the `valid && ready` cycle.
- Reset mid-DATA: asserting `reset` for 1 clock gives `tx=0`, `active=0`, `ready=1` on the next clock. The pending held word is never transmitted. Without `COAX_TX_PARITY_EN`, the single-word frame lasts 168 clocks.

Source files
------------

// File: rtl/coax_tx_sequencer_if.sv
// Host-side word handshake for the coax transmit sequencer.
// The host drives data/valid and the sequencer returns ready.
interface coax_tx_sequencer_if;
    logic [9:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/coax_tx_sequencer.sv
// Frame-level transmit controller for the 3270 coax line.
// A frame is a start sequence (5 quiesce bits plus a code violation), then one
// or more words, then an end sequence. Each word is a sync '1', 10 data bits
// MSB first, and, when COAX_TX_PARITY_EN is defined, an even-parity bit.
// Each bit drives ~b for the first half-period and b for the second.
// A one-word holding register lets the next word queue up while the current
// word is on the line, so back-to-back words share one frame.
module coax_tx_sequencer #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    coax_tx_sequencer_if.slave   bus,
    output logic                 tx,
    output logic                 active
);

    localparam int PHASE_W = $clog2(CLOCKS_PER_BIT) + 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLOCKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(CLOCKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CV,
        ST_SYNC,
        ST_DATA,
`ifdef COAX_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_END
    } state_t;

    state_t               state, state_next;
    logic [PHASE_W-1:0]   phase;
    logic [3:0]           bit_cnt, bit_next;
    logic [2:0]           half_cnt, half_next;
    logic                 full;
    logic [9:0]           hold;
    logic [9:0]           shift;
`ifdef COAX_TX_PARITY_EN
    logic                 par;
`endif
    logic                 accept;
    logic                 load;
    logic                 word_done;
    logic                 bit_end;
    logic                 half_end;
    logic                 first_half;

    // Line level for one bit cell: inverted in the first half, true in the second.
    function automatic logic encode_bit(input logic b, input logic in_first_half);
        return in_first_half ? ~b : b;
    endfunction

    // Parity bit that makes the count of ones over word plus parity even.
    function automatic logic even_parity(input logic [9:0] w);
        return ^w;
    endfunction

    assign bus.ready  = ~full;
    assign accept     = bus.valid & ~full;
    assign bit_end    = (phase == PHASE_LAST);
    assign half_end   = bit_end | (phase == HALF_LAST);
    assign first_half = (phase <= HALF_LAST);

    // Control state: FSM state, bit timing counters and the holding-register flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
            full     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_next;
            half_cnt <= half_next;
            if (state == ST_IDLE || bit_end) begin
                phase <= '0;
            end else begin
                phase <= phase + PHASE_W'(1);
            end
            if (load) begin
                full <= 1'b0;
            end else if (accept) begin
                full <= 1'b1;
            end
        end
    end

    // Word datapath: capture on handshake, move to the shifter on SYNC entry.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= bus.data;
        end
        if (load) begin
            shift <= hold;
`ifdef COAX_TX_PARITY_EN
            par   <= even_parity(hold);
`endif
        end else if (state == ST_DATA && bit_end) begin
            shift <= {shift[8:0], 1'b0};
        end
    end

    // Next-state, counter updates and line level for the current bit cell.
    always_comb begin
        state_next = state;
        bit_next   = bit_cnt;
        half_next  = half_cnt;
        load       = 1'b0;
        word_done  = 1'b0;
        tx         = 1'b0;
        active     = 1'b1;
        case (state)
            ST_IDLE: begin
                active = 1'b0;
                if (full) begin
                    state_next = ST_START;
                    bit_next   = '0;
                end
            end
            ST_START: begin
                tx = encode_bit(1'b1, first_half);
                if (bit_end) begin
                    if (bit_cnt == 4'd4) begin
                        state_next = ST_CV;
                        half_next  = '0;
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end
            end
            ST_CV: begin
                tx = (half_cnt >= 3'd3);
                if (half_end) begin
                    if (half_cnt == 3'd5) begin
                        state_next = ST_SYNC;
                        load       = 1'b1;
                    end else begin
                        half_next = half_cnt + 3'd1;
                    end
                end
            end
            ST_SYNC: begin
                tx = encode_bit(1'b1, first_half);
                if (bit_end) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                tx = encode_bit(shift[9], first_half);
                if (bit_end) begin
                    if (bit_cnt == 4'd9) begin
`ifdef COAX_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        word_done  = 1'b1;
`endif
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end
            end
`ifdef COAX_TX_PARITY_EN
            ST_PARITY: begin
                tx = encode_bit(par, first_half);
                if (bit_end) begin
                    word_done = 1'b1;
                end
            end
`endif
            ST_END: begin
                tx = (bit_cnt == 4'd0) ? encode_bit(1'b0, first_half) : 1'b1;
                if (bit_end) begin
                    if (bit_cnt == 4'd1) begin
                        state_next = ST_IDLE;
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // A queued word continues the frame; otherwise close it.
        if (word_done) begin
            if (full) begin
                state_next = ST_SYNC;
                load       = 1'b1;
            end else begin
                state_next = ST_END;
                bit_next   = '0;
            end
        end
    end

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// Self-checking bench for coax_tx_sequencer. Expected line waveforms are built
// from the frame format (start, code violation, words, end) as a list of levels
// per clock and compared with what the line shows while active is high.
// Follows COAX_TX_PARITY_EN the same way the design does.
module tb_coax_tx_sequencer;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
`ifdef COAX_TX_PARITY_EN
    localparam int WB = 12;
`else
    localparam int WB = 11;
`endif
    localparam int S0 = 8 * CPB;          // index of the first SYNC clock in a frame

    typedef logic [9:0] word_q_t[$];

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic active;

    coax_tx_sequencer_if bus();

    coax_tx_sequencer #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .tx     (tx),
        .active (active)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_q[$];
    logic got_q[$];
    logic rdy_q[$];
    bit   cap_ok;
    int   cap_gap;
    logic cap_txa;

    function automatic void push_bit(input logic b);
        for (int i = 0; i < HALF; i++) exp_q.push_back(~b);
        for (int i = 0; i < HALF; i++) exp_q.push_back(b);
    endfunction

    function automatic void build_frame(input word_q_t w);
        exp_q.delete();
        for (int i = 0; i < 5; i++) push_bit(1'b1);
        for (int i = 0; i < 3 * HALF; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 3 * HALF; i++) exp_q.push_back(1'b1);
        foreach (w[k]) begin
            int ones;
            ones = 0;
            push_bit(1'b1);
            for (int i = 9; i >= 0; i--) begin
                push_bit(w[k][i]);
                ones += int'(w[k][i]);
            end
            if (WB == 12) push_bit(logic'(ones % 2));
        end
        push_bit(1'b0);
        for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Called at a negedge: waits for active, then records tx/ready until it falls.
    task automatic capture(input int max_wait);
        int n;
        got_q.delete();
        rdy_q.delete();
        cap_ok  = 1'b1;
        cap_gap = 0;
        n       = 0;
        while (active !== 1'b1 && cap_gap < max_wait) begin
            cap_gap++;
            @(negedge clk);
        end
        if (active !== 1'b1) begin
            cap_ok = 1'b0;
        end else begin
            while (active === 1'b1 && n < 2000) begin
                got_q.push_back(tx);
                rdy_q.push_back(bus.ready);
                n++;
                @(negedge clk);
            end
            if (n >= 2000) cap_ok = 1'b0;
        end
        cap_txa = tx;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [9:0] d, output bit ok);
        ok        = 1'b0;
        bus.data  = d;
        bus.valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.valid = 1'b0;
        bus.data  = 10'($urandom_range(0, 1023));
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.valid = 1'b0;
        bus.data  = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) $display("FAIL reset_tx: got %b required 0", tx); else n_pass++;
        n_checks++;
        if (active !== 1'b0) $display("FAIL reset_active: got %b required 0", active); else n_pass++;
        n_checks++;
        if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", bus.ready); else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int idx;
        word_q_t w;
        send_word(10'h001, ok);
        n_checks++;
        if (!ok || active !== 1'b0 || bus.ready !== 1'b0)
            $display("FAIL single_accept: ok=%0d active=%b ready=%b, required 1 0 0", ok, active, bus.ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (active !== 1'b1) $display("FAIL single_latency: active=%b two clocks after accept, required 1", active);
        else n_pass++;
        capture(1);
        n_checks++;
        if (!cap_ok || got_q.size() != (WB + 10) * CPB)
            $display("FAIL single_length: got %0d active clocks, required %0d", got_q.size(), (WB + 10) * CPB);
        else n_pass++;
        w.push_back(10'h001);
        build_frame(w);
        idx = first_diff();
        n_checks++;
        if (idx != -1)
            $display("FAIL single_wave: differs at clock %0d (got %0d levels, required %0d)", idx, got_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (cap_txa !== 1'b0) $display("FAIL single_idle_tx: got %b required 0", cap_txa); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_parity();
        logic [9:0] vals[2];
        bit ok;
        int idx;
        word_q_t w;
        vals[0] = 10'h3FF;
        vals[1] = 10'h2A5;
        for (int v = 0; v < 2; v++) begin
            send_word(vals[v], ok);
            capture(20);
            w.delete();
            w.push_back(vals[v]);
            build_frame(w);
            idx = first_diff();
            n_checks++;
            if (!ok || !cap_ok || idx != -1)
                $display("FAIL parity_wave_%h: differs at clock %0d (ok=%0d cap=%0d)", vals[v], idx, ok, cap_ok);
            else n_pass++;
            n_checks++;
            if (got_q.size() != (WB + 10) * CPB)
                $display("FAIL parity_length_%h: got %0d required %0d", vals[v], got_q.size(), (WB + 10) * CPB);
            else n_pass++;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1;
        int idx;
        int s1;
        word_q_t w;
        w.push_back(10'($urandom_range(0, 1023)));
        w.push_back(10'($urandom_range(0, 1023)));
        s1 = S0 + WB * CPB;
        send_word(w[0], ok0);
        fork
            capture(10);
            begin
                repeat (80) @(negedge clk);
                send_word(w[1], ok1);
            end
        join
        build_frame(w);
        idx = first_diff();
        n_checks++;
        if (!ok0 || !ok1 || !cap_ok || idx != -1)
            $display("FAIL b2b_wave: differs at clock %0d (got %0d levels, required %0d)", idx, got_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (rdy_q.size() <= s1 || rdy_q[s1] !== 1'b1)
            $display("FAIL b2b_ready_rise: ready at second SYNC clock %0d is not 1 (levels %0d)", s1, rdy_q.size());
        else n_pass++;
        n_checks++;
        if (rdy_q.size() <= s1 || rdy_q[s1-1] !== 1'b0)
            $display("FAIL b2b_ready_low: ready before second SYNC is not 0 (levels %0d)", rdy_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_late_word();
        bit ok0, ok1;
        int idx;
        word_q_t w0, w1;
        w0.push_back(10'($urandom_range(0, 1023)));
        w1.push_back(10'($urandom_range(0, 1023)));
        send_word(w0[0], ok0);
        fork
            capture(10);
            begin
                repeat (S0 + WB * CPB + 3) @(negedge clk);
                send_word(w1[0], ok1);
            end
        join
        build_frame(w0);
        idx = first_diff();
        n_checks++;
        if (!ok0 || !cap_ok || idx != -1)
            $display("FAIL late_first_wave: differs at clock %0d (got %0d levels, required %0d)", idx, got_q.size(), exp_q.size());
        else n_pass++;
        capture(20);
        n_checks++;
        if (cap_gap < 1) $display("FAIL late_gap: inactive clocks %0d, required at least 1", cap_gap); else n_pass++;
        build_frame(w1);
        idx = first_diff();
        n_checks++;
        if (!ok1 || !cap_ok || idx != -1)
            $display("FAIL late_second_wave: differs at clock %0d (got %0d levels, required %0d)", idx, got_q.size(), exp_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_handshake_hold();
        word_q_t acc;
        int idx;
        int rises;
        fork
            capture(20);
            begin
                int g;
                g = 0;
                while (acc.size() < 3 && g < 5000) begin
                    bus.data  = 10'($urandom_range(0, 1023));
                    bus.valid = 1'b1;
                    if (bus.ready === 1'b1) acc.push_back(bus.data);
                    @(negedge clk);
                    g++;
                end
                bus.valid = 1'b0;
            end
        join
        n_checks++;
        if (acc.size() != 3) $display("FAIL hold_accepts: got %0d words, required 3", acc.size()); else n_pass++;
        build_frame(acc);
        idx = first_diff();
        n_checks++;
        if (!cap_ok || idx != -1)
            $display("FAIL hold_wave: differs at clock %0d (got %0d levels, required %0d)", idx, got_q.size(), exp_q.size());
        else n_pass++;
        rises = 0;
        for (int i = 1; i < rdy_q.size(); i++) if (rdy_q[i] === 1'b1 && rdy_q[i-1] === 1'b0) rises++;
        n_checks++;
        if (rises != 3) $display("FAIL hold_ready_rises: got %0d, required 3", rises); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            word_q_t w;
            int k;
            int idx;
            bit okall;
            k = $urandom_range(1, 3);
            okall = 1'b1;
            for (int j = 0; j < k; j++) w.push_back(10'($urandom_range(0, 1023)));
            fork
                capture(20);
                begin
                    for (int j = 0; j < k; j++) begin
                        bit ok;
                        if (j > 0) begin
                            int g;
                            g = 0;
                            while (bus.ready !== 1'b1 && g < 1000) begin
                                g++;
                                @(negedge clk);
                            end
                            repeat ($urandom_range(0, 3)) @(negedge clk);
                        end
                        send_word(w[j], ok);
                        if (!ok) okall = 1'b0;
                    end
                end
            join
            build_frame(w);
            idx = first_diff();
            n_checks++;
            if (!okall || !cap_ok || idx != -1)
                $display("FAIL random_wave_%0d: %0d words, differs at clock %0d (got %0d levels, required %0d)",
                         f, k, idx, got_q.size(), exp_q.size());
            else n_pass++;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_data();
        bit ok0, ok1, ok2;
        int act;
        send_word(10'($urandom_range(0, 1023)), ok0);
        repeat (80) @(negedge clk);
        send_word(10'($urandom_range(0, 1023)), ok1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (tx !== 1'b0 || active !== 1'b0) $display("FAIL midreset_line: tx=%b active=%b, required 0 0", tx, active);
        else n_pass++;
        n_checks++;
        if (!ok0 || !ok1 || bus.ready !== 1'b1) $display("FAIL midreset_ready: got %b required 1", bus.ready);
        else n_pass++;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            if (active !== 1'b0) act++;
            @(negedge clk);
        end
        n_checks++;
        if (act != 0) $display("FAIL midreset_discard: active for %0d clocks, required 0", act); else n_pass++;
        send_word(10'($urandom_range(0, 1023)), ok2);
        capture(20);
        n_checks++;
        if (!ok2 || !cap_ok || got_q.size() != (WB + 10) * CPB)
            $display("FAIL midreset_next_length: got %0d required %0d", got_q.size(), (WB + 10) * CPB);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_late_word();
        test_handshake_hold();
        test_random();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d before timeout", n_pass, n_checks);
        $fatal(1);
    end

endmodule
